// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for a downstream shift-register chain.
// One-word hold buffer in front of an active shift register allows gapless streaming.
module serial_word_feeder #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             negative_reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             out,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            r_state;
  logic [WIDTH-1:0]  r_hold;
  logic [WIDTH-1:0]  r_act;
  logic              r_hold_full;
  logic [CntW-1:0]   r_cnt;
  logic              r_out;
  logic              r_out_valid;
  logic              r_out_first;
  logic              r_out_last;

  logic              w_act_valid;
  logic              w_cnt_last;
  logic              w_act_free;
  logic              w_xfer;
  logic              w_accept;
  logic [CntW-1:0]   w_idx;

  assign w_act_valid = (r_state == StShift);
  assign w_cnt_last  = (r_cnt == CntW'(WIDTH - 1));
  // Active register frees up on the edge that emits its last bit, so hold can refill it gaplessly.
  assign w_act_free  = !w_act_valid || (shift_en && w_cnt_last);
  assign w_xfer      = r_hold_full && w_act_free;
  assign w_accept    = in_valid && !r_hold_full;
  assign w_idx       = LSB_FIRST ? r_cnt : (CntW'(WIDTH - 1) - r_cnt);

  always_ff @(posedge clock or negedge negative_reset) begin
    if (!negative_reset) begin
      r_state     <= StIdle;
      r_hold      <= '0;
      r_act       <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
      r_out       <= IDLE_LEVEL;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold      <= in_data;
        r_hold_full <= 1'b1;
      end else if (w_xfer) begin
        r_hold_full <= 1'b0;
      end

      if (shift_en) begin
        if (w_act_valid) begin
          r_out       <= r_act[w_idx];
          r_out_valid <= 1'b1;
          r_out_first <= (r_cnt == '0);
          r_out_last  <= w_cnt_last;
          r_cnt       <= w_cnt_last ? '0 : r_cnt + CntW'(1);
          if (w_cnt_last) begin
            r_state <= StIdle;
          end
        end else begin
          r_out       <= IDLE_LEVEL;
          r_out_valid <= 1'b0;
          r_out_first <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end else begin
        r_out_valid <= 1'b0;
        r_out_first <= 1'b0;
        r_out_last  <= 1'b0;
      end

      // Placed last so a transfer overrides the idle-on-last-bit update above.
      if (w_xfer) begin
        r_act   <= r_hold;
        r_cnt   <= '0;
        r_state <= StShift;
      end
    end
  end

  assign in_ready  = !r_hold_full;
  assign busy      = w_act_valid | r_hold_full;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Self-checking bench: vector table, directed corner sequences and random traffic
// checked against a bit-list reference model, for an 8-bit LSB-first and a 4-bit MSB-first instance.
module tb_serial_word_feeder;

  logic clock;
  logic negative_reset;

  logic [7:0] d_a;
  logic       iv_a, sh_a, rdy_a, out_a, ov_a, of_a, ol_a, busy_a;
  logic [3:0] d_b;
  logic       iv_b, sh_b, rdy_b, out_b, ov_b, of_b, ol_b, busy_b;

  int n_checks = 0;
  int n_err    = 0;

  serial_word_feeder #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clock(clock), .negative_reset(negative_reset), .in_data(d_a), .in_valid(iv_a),
    .in_ready(rdy_a), .shift_en(sh_a), .out(out_a), .out_valid(ov_a), .out_first(of_a),
    .out_last(ol_a), .busy(busy_a)
  );

  serial_word_feeder #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clock(clock), .negative_reset(negative_reset), .in_data(d_b), .in_valid(iv_b),
    .in_ready(rdy_b), .shift_en(sh_b), .out(out_b), .out_valid(ov_b), .out_first(of_b),
    .out_last(ol_b), .busy(busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a held word plus a list of {first,last,data} bits still to emit.
  logic [31:0] m_hold [2];
  bit          m_hf   [2];
  logic [2:0]  m_lst  [2][32];
  int          m_n    [2];
  bit          m_out  [2];
  bit          m_vld  [2];
  bit          m_fst  [2];
  bit          m_ls   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hold[k] = '0; m_hf[k] = 0; m_n[k] = 0;
      m_out[k] = 0; m_vld[k] = 0; m_fst[k] = 0; m_ls[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int w, input bit lsb, input bit sh,
                            input bit iv, input logic [31:0] d);
    bit free, xfer, acc;
    int idx;
    free = (m_n[k] == 0) || (sh && m_n[k] == 1);
    xfer = m_hf[k] && free;
    acc  = iv && !m_hf[k];
    m_vld[k] = 0; m_fst[k] = 0; m_ls[k] = 0;
    if (sh) begin
      if (m_n[k] > 0) begin
        {m_fst[k], m_ls[k], m_out[k]} = m_lst[k][0];
        m_vld[k] = 1;
        for (int j = 0; j < 31; j++) m_lst[k][j] = m_lst[k][j+1];
        m_n[k]--;
      end else begin
        m_out[k] = 0;
      end
    end
    if (xfer) begin
      for (int i = 0; i < w; i++) begin
        idx = lsb ? i : (w - 1 - i);
        m_lst[k][i] = {(i == 0), (i == w - 1), m_hold[k][idx]};
      end
      m_n[k]  = w;
      m_hf[k] = 0;
    end
    if (acc) begin
      m_hold[k] = d;
      m_hf[k]   = 1;
    end
  endtask

  function automatic logic [5:0] model_vec(input int k);
    return {m_out[k], m_vld[k], m_fst[k], m_ls[k], !m_hf[k], (m_hf[k] || m_n[k] > 0)};
  endfunction

  task automatic step();
    @(posedge clock);
    model_step(0, 8, 1'b1, sh_a, iv_a, {24'b0, d_a});
    model_step(1, 4, 1'b0, sh_b, iv_b, {28'b0, d_b});
    #1;
    check("model_a", {26'b0, out_a, ov_a, of_a, ol_a, rdy_a, busy_a}, {26'b0, model_vec(0)});
    check("model_b", {26'b0, out_b, ov_b, of_b, ol_b, rdy_b, busy_b}, {26'b0, model_vec(1)});
  endtask

  task automatic idle_inputs();
    iv_a = 0; sh_a = 0; d_a = '0;
    iv_b = 0; sh_b = 0; d_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    negative_reset = 1'b0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset_a", {26'b0, out_a, ov_a, of_a, ol_a, rdy_a, busy_a}, 32'b000010);
    check("reset_b", {26'b0, out_b, ov_b, of_b, ol_b, rdy_b, busy_b}, 32'b000010);
    #2 negative_reset = 1'b1;
  endtask

  typedef struct packed {
    logic       sh;
    logic       iv;
    logic [7:0] d;
    logic [5:0] exp;  // {out, out_valid, out_first, out_last, in_ready, busy}
  } vec_t;

  vec_t tbl [11];

  initial begin
    int acc_cnt, last_cnt, nbits, run, maxrun, nvalid, prev_t, gap_ok;
    logic [15:0] stream;
    logic [7:0]  word;
    logic [3:0]  nib;
    int first_pos, last_pos;
    logic [7:0] words [2];

    tbl[0]  = '{1'b1, 1'b1, 8'hA5, 6'b000001};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 6'b000011};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 6'b111011};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 6'b010011};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 6'b110011};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 6'b010011};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 6'b010011};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 6'b110011};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 6'b010011};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 6'b110110};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 6'b000010};

    do_reset();

    // Single word 0xA5, shift_en held high.
    for (int i = 0; i < 11; i++) begin
      sh_a = tbl[i].sh; iv_a = tbl[i].iv; d_a = tbl[i].d;
      step();
      check($sformatf("table_%0d", i), {26'b0, out_a, ov_a, of_a, ol_a, rdy_a, busy_a},
            {26'b0, tbl[i].exp});
    end

    // Back-to-back 0xA5, 0x3C: 16 contiguous valid bits.
    words[0] = 8'hA5; words[1] = 8'h3C;
    acc_cnt = 0; run = 0; maxrun = 0; nvalid = 0; stream = '0;
    sh_a = 1;
    for (int c = 0; c < 26; c++) begin
      iv_a = (acc_cnt < 2);
      d_a  = (acc_cnt < 2) ? words[acc_cnt] : 8'h00;
      if (iv_a && rdy_a) acc_cnt++;
      step();
      if (ov_a) begin
        if (nvalid < 16) stream[nvalid] = out_a;
        nvalid++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    check("b2b_valid_count", nvalid, 16);
    check("b2b_gapless_run", maxrun, 16);
    check("b2b_stream", {16'b0, stream}, 32'h3CA5);

    // Paced shift every third cycle, word 0x81.
    idle_inputs();
    nvalid = 0; word = '0; prev_t = -1; gap_ok = 1;
    for (int c = 0; c < 40; c++) begin
      iv_a = (c == 0); d_a = (c == 0) ? 8'h81 : 8'h00;
      sh_a = (c % 3 == 2);
      step();
      if (ov_a) begin
        if (nvalid < 8) word[nvalid] = out_a;
        if (prev_t >= 0 && c - prev_t != 3) gap_ok = 0;
        prev_t = c; nvalid++;
      end
    end
    check("paced_pulses", nvalid, 8);
    check("paced_spacing", gap_ok, 1);
    check("paced_word", {24'b0, word}, 32'h81);

    // Backpressure: in_valid stuck high with changing data.
    idle_inputs();
    acc_cnt = 0; last_cnt = 0;
    sh_a = 1;
    for (int c = 0; c < 60; c++) begin
      iv_a = (c < 30);
      d_a  = 8'($urandom);
      if (iv_a && rdy_a) acc_cnt++;
      step();
      if (ov_a && ol_a) last_cnt++;
    end
    check("bp_once_each", last_cnt, acc_cnt);
    check("bp_drained_busy", {31'b0, busy_a}, 32'd0);

    // Asynchronous reset in the middle of 0xF0.
    idle_inputs();
    iv_a = 1; d_a = 8'hF0; sh_a = 1;
    step();
    iv_a = 0;
    for (int c = 0; c < 4; c++) step();
    #2 negative_reset = 1'b0;
    #1;
    check("async_reset_a", {26'b0, out_a, ov_a, of_a, ol_a, rdy_a, busy_a}, 32'b000010);
    model_reset();
    idle_inputs();
    @(posedge clock);
    #3 negative_reset = 1'b1;
    iv_a = 1; d_a = 8'h0F; sh_a = 1;
    step();
    iv_a = 0; nbits = 0; word = '0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (ov_a) begin
        if (nbits < 8) word[nbits] = out_a;
        nbits++;
      end
    end
    check("post_reset_bits", nbits, 8);
    check("post_reset_word", {24'b0, word}, 32'h0F);

    // MSB-first 4-bit instance, word 0xB.
    idle_inputs();
    iv_b = 1; d_b = 4'hB; sh_b = 1;
    step();
    iv_b = 0; nbits = 0; nib = '0; first_pos = -1; last_pos = -1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ov_b) begin
        if (nbits < 4) nib = {nib[2:0], out_b};
        if (of_b) first_pos = nbits;
        if (ol_b) last_pos = nbits;
        nbits++;
      end
    end
    check("msb_bits", nbits, 4);
    check("msb_word", {28'b0, nib}, 32'hB);
    check("msb_first_pos", first_pos, 0);
    check("msb_last_pos", last_pos, 3);

    // Random traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      sh_a = ($urandom_range(0, 3) != 0);
      iv_a = $urandom_range(0, 1) == 1;
      d_a  = 8'($urandom);
      sh_b = ($urandom_range(0, 2) != 0);
      iv_b = $urandom_range(0, 1) == 1;
      d_b  = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Parallel-to-serial stage sitting directly upstream of the serial shift-register chain; drives that chain's single-bit data input.
- Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and emits bits one per shift tick.
- Supports gapless back-to-back words and marks the first and last bit of each word.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 shifted out first; 0 = bit WIDTH-1 first.
- IDLE_LEVEL, 0, value driven on out after reset and when no word is being shifted.

Ports:
- clock  input  1  rising-edge clock.
- negative_reset  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  parallel word to serialise.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  bit-rate tick; one bit is emitted per clock edge with shift_en=1.
- out  output  1  serial data to the downstream shift register.
- out_valid  output  1  out was updated with a data bit on the last edge.
- out_first  output  1  qualifies out as the first bit of a word.
- out_last  output  1  qualifies out as the last bit of a word.
- busy  output  1  a word is held or being shifted.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-low (negative_reset).
- Reset (asynchronous assert, synchronous release on the next edge):
  - Hold and active registers are emptied; bit counter = 0.
  - in_ready=1, out=IDLE_LEVEL, out_valid=0, out_first=0, out_last=0, busy=0.
  - A word in flight is discarded; no partial word resumes after release.
- Storage: hold register (hold_full flag) and active register (act_valid flag, bit counter 0..WIDTH-1).
- Handshake:
  - in_ready = !hold_full, registered-state only; there is no combinational path from in_valid.
  - Accept occurs on an edge with in_valid & in_ready; hold is loaded with in_data and hold_full=1.
  - Holding in_data while in_ready=0 has no effect.
- Transfer: on any edge where hold_full=1 and the active register is free, act <= hold, counter <= 0, hold_full <= 0. Transfer is independent of shift_en. The active register is free when:
  - act_valid=0, or
  - shift_en=1 and counter==WIDTH-1 (last bit emitted this edge).
- Same-edge ordering: transfer and accept cannot occur on the same edge, because accept requires hold empty.
- Shift, on an edge with shift_en=1:
  - If act_valid: out <= selected bit (counter index if LSB_FIRST, else WIDTH-1-counter), out_valid <= 1, out_first <= (counter==0), out_last <= (counter==WIDTH-1), counter++.
  - On the last bit: act_valid <= 0 unless a transfer occurs on the same edge.
  - If !act_valid: out <= IDLE_LEVEL, out_valid/first/last <= 0.
- Edge with shift_en=0: out holds its value; out_valid, out_first, out_last <= 0. The counter and registers are frozen except for transfer and accept.
- Latency: accept at edge E puts the word in hold; transfer at E+1 (if active is free); first bit is emitted on the first shift_en edge at or after E+2.
- Gapless streaming: if hold_full when the last bit is emitted, the next shift_en edge emits bit 0 of the next word. No idle bit is inserted.
- busy = act_valid | hold_full (registered).
- Implementation uses two states, IDLE (!act_valid) and SHIFT (act_valid); hold_full is orthogonal to the state.

Test Plan:
- Single word, LSB_FIRST=1, shift_en=1 constantly, in_data=0xA5 accepted at edge 0 -> out_valid high for edges 2..9 with out=1,0,1,0,0,1,0,1; out_first at edge 2 only, out_last at edge 9 only; busy=0 after edge 9; out=IDLE_LEVEL after edge 10.
- Back-to-back, 0xA5 then 0x3C presented continuously, shift_en=1 -> 16 consecutive out_valid cycles with no gap; second word LSB-first = 0,0,1,1,1,1,0,0; in_ready low while hold is full.
- Paced shift, shift_en high every 3rd cycle, word 0x81 -> exactly 8 out_valid pulses spaced 3 cycles apart; out holds its value between pulses; bits 1,0,0,0,0,0,0,1.
- Backpressure: fill hold and active, keep in_valid=1 with a changing in_data -> in_ready=0 and no accept until the active word's last bit; each word is emitted exactly once.
- Reset mid-word, negative_reset low asynchronously after 3 bits of 0xF0 -> outputs go to reset values immediately, without waiting for a clock edge; after release, the bench sends 0x0F -> only 0x0F bits appear, with no leftover 0xF0 bits.
- MSB-first, LSB_FIRST=0, WIDTH=4, in_data=0xB -> bits 1,0,1,1 with out_first on the first bit and out_last on the fourth.
